barcode_reader: RTL and testbench

Serial receiver for the payment barcode frame: hunts for a start marker, shifts in the 5-bit value-to-pay and its check bit P, and verifies the check bit, stop bit and value legality. It sits at the scanner end of the barcode path, decoding the frame the generator side emits. It returns the recovered value plus per-frame status to downstream display/accounting logic.

---
 rtl/barcode_pkg.sv | 32 +++
 rtl/barcode_if.sv | 24 ++
 rtl/barcode_check.sv | 13 +
 rtl/barcode_reader.sv | 155 +++++++++++++++
 tb/tb_barcode_reader.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/barcode_pkg.sv
// Shared definitions for the payment barcode path (reader and generator side).
package barcode_pkg;

  localparam int unsigned ID_DIGIT_SUM  = 54;
  localparam logic [2:0]  START_PATTERN = 3'b101;
  localparam int          VALUE_W       = 5;

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  // P is 1 when (ID digit sum + decimal digit sum of value) is odd.
  function automatic logic expected_p(input logic [VALUE_W-1:0] value);
    logic [31:0] v;
    logic [31:0] sum;
    v   = 32'(value);
    sum = ID_DIGIT_SUM + (v / 32'd10) + (v % 32'd10);
    return (sum % 32'd2) == 32'd1;
  endfunction

  function automatic logic value_legal(input logic [VALUE_W-1:0] value);
    logic ok;
    case (value)
      5'd0, 5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12,
      5'd14, 5'd16, 5'd20, 5'd24, 5'd28: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/barcode_if.sv
// Serial sample input and decoded-frame status bundle of the barcode reader.
interface barcode_if;
  import barcode_pkg::*;

  logic               barBit;
  logic               barValid;
  logic [VALUE_W-1:0] valueOut;
  logic               frameDone;
  logic               codeOk;
  logic               parityError;
  logic               frameError;
  logic               busy;

  modport master (
    output barBit, barValid,
    input  valueOut, frameDone, codeOk, parityError, frameError, busy
  );

  modport slave (
    input  barBit, barValid,
    output valueOut, frameDone, codeOk, parityError, frameError, busy
  );

endinterface

// File: rtl/barcode_check.sv
// Combinational check-bit and legality evaluation of a received value.
module barcode_check
  import barcode_pkg::*;
(
  input  logic [VALUE_W-1:0] value,
  output logic               expectedP,
  output logic               legal
);

  assign expectedP = expected_p(value);
  assign legal     = value_legal(value);

endmodule

// File: rtl/barcode_reader.sv
// Barcode frame receiver: start-marker hunt, value/P/stop capture, status
// evaluation and inter-sample timeout.
module barcode_reader
  import barcode_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic     clk,
  input  logic     rst_n,
  barcode_if.slave bus
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [1:0]         state_q, state_d;
  logic [2:0]         hist_q, hist_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [VALUE_W-1:0] shift_q, shift_d;
  logic               rx_p_q, rx_p_d;
  logic [15:0]        gap_q, gap_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               frame_done_q, frame_done_d;
  logic               code_ok_q, code_ok_d;
  logic               parity_error_q, parity_error_d;
  logic               frame_error_q, frame_error_d;

  logic               expected_p_bit;
  logic               legal;
  logic [2:0]         hist_shift;
  logic               timeout;

  barcode_check u_check (
    .value     (shift_q),
    .expectedP (expected_p_bit),
    .legal     (legal)
  );

  assign hist_shift = {hist_q[1:0], bus.barBit};
  // A sample arriving on the would-be timeout cycle wins over the timeout.
  assign timeout = (state_q != HUNT) && !bus.barValid && ((gap_q + 16'd1) == TIMEOUT_LIMIT);

  always_comb begin
    state_d        = state_q;
    hist_d         = 3'b000;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_p_d         = rx_p_q;
    value_d        = value_q;
    frame_done_d   = 1'b0;
    code_ok_d      = code_ok_q;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;

    if (state_q == HUNT || bus.barValid) begin
      gap_d = 16'd0;
    end else if (gap_q != 16'hFFFF) begin
      gap_d = gap_q + 16'd1;
    end else begin
      gap_d = gap_q;
    end

    case (state_q)
      HUNT: begin
        hist_d = hist_q;
        if (bus.barValid) begin
          if (hist_shift == START_PATTERN) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
            hist_d    = 3'b000;
          end else begin
            hist_d = hist_shift;
          end
        end
      end
      DATA: begin
        if (bus.barValid) begin
          shift_d = {shift_q[VALUE_W-2:0], bus.barBit};
          if (bit_cnt_q == 3'd4) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bus.barValid) begin
          rx_p_d  = bus.barBit;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bus.barValid) begin
          state_d        = HUNT;
          frame_done_d   = 1'b1;
          code_ok_d      = 1'b0;
          parity_error_d = 1'b0;
          frame_error_d  = 1'b0;
          if (bus.barBit || !legal) begin
            frame_error_d = 1'b1;
          end else if (rx_p_q != expected_p_bit) begin
            parity_error_d = 1'b1;
          end else begin
            code_ok_d = 1'b1;
            value_d   = shift_q;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (timeout) begin
      state_d        = HUNT;
      frame_done_d   = 1'b1;
      code_ok_d      = 1'b0;
      parity_error_d = 1'b0;
      frame_error_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= HUNT;
      hist_q         <= 3'b000;
      bit_cnt_q      <= 3'd0;
      shift_q        <= '0;
      rx_p_q         <= 1'b0;
      gap_q          <= 16'd0;
      value_q        <= '0;
      frame_done_q   <= 1'b0;
      code_ok_q      <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      hist_q         <= hist_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_p_q         <= rx_p_d;
      gap_q          <= gap_d;
      value_q        <= value_d;
      frame_done_q   <= frame_done_d;
      code_ok_q      <= code_ok_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
    end
  end

  assign bus.valueOut    = value_q;
  assign bus.frameDone   = frame_done_q;
  assign bus.codeOk      = code_ok_q;
  assign bus.parityError = parity_error_q;
  assign bus.frameError  = frame_error_q;
  assign bus.busy        = (state_q != HUNT);

endmodule

// File: tb/tb_barcode_reader.sv
// Scoreboard bench for barcode_reader: directed frames push expected results,
// a negedge monitor pops and compares on every frameDone.
module tb_barcode_reader;
  import barcode_pkg::*;

  localparam int TIMEOUT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  barcode_if bus();

  barcode_reader #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0] value;
    logic       ok;
    logic       perr;
    logic       ferr;
    int         cycle;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks    = 0;
  int   errors    = 0;
  int   cycle_cnt = 0;
  int   last_edge = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Every frameDone cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.frameDone === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_frameDone actual=1 expected=0 cycle=%0d", cycle_cnt);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("done_cycle",  cycle_cnt,       mon_e.cycle);
        checkOutput("valueOut",    bus.valueOut,    mon_e.value);
        checkOutput("codeOk",      bus.codeOk,      mon_e.ok);
        checkOutput("parityError", bus.parityError, mon_e.perr);
        checkOutput("frameError",  bus.frameError,  mon_e.ferr);
        checkOutput("busy_at_done", bus.busy,       1'b0);
      end
    end
  end

  task automatic pushExpect(input logic [4:0] v, input logic ok, input logic perr, input logic ferr, input int cyc);
    exp_t e;
    e.value = v; e.ok = ok; e.perr = perr; e.ferr = ferr; e.cycle = cyc;
    sb.push_back(e);
  endtask

  task automatic driveBit(input logic b);
    @(negedge clk);
    bus.barBit   = b;
    bus.barValid = 1'b1;
    @(posedge clk);
    #1;
    last_edge = cycle_cnt;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.barValid = 1'b0;
      bus.barBit   = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendGapped(input logic b, input int gap);
    if (gap > 0) idle(gap);
    driveBit(b);
  endtask

  // Full frame 1,0,1,value MSB first,P,stop; the result is due on the stop edge.
  task automatic applyStimulus(input logic [4:0] v, input logic p, input logic stop, input int gap,
                               input logic [4:0] exp_val, input logic ok, input logic perr, input logic ferr);
    sendGapped(1'b1, gap);
    sendGapped(1'b0, gap);
    sendGapped(1'b1, gap);
    for (int i = 4; i >= 0; i--) sendGapped(v[i], gap);
    sendGapped(p, gap);
    sendGapped(stop, gap);
    pushExpect(exp_val, ok, perr, ferr, last_edge);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valueOut"},    bus.valueOut,    0);
    checkOutput({tag, "_frameDone"},   bus.frameDone,   0);
    checkOutput({tag, "_codeOk"},      bus.codeOk,      0);
    checkOutput({tag, "_parityError"}, bus.parityError, 0);
    checkOutput({tag, "_frameError"},  bus.frameError,  0);
    checkOutput({tag, "_busy"},        bus.busy,        0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.barBit   = 1'b0;
    bus.barValid = 1'b0;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Back-to-back: good 12, bad P on 20, bad stop on 6, illegal 3
    applyStimulus(5'd12, 1'b1, 1'b0, 0, 5'd12, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd20, 1'b1, 1'b0, 0, 5'd12, 1'b0, 1'b1, 1'b0);
    applyStimulus(5'd6,  1'b0, 1'b1, 0, 5'd12, 1'b0, 1'b0, 1'b1);
    applyStimulus(5'd3,  1'b1, 1'b0, 0, 5'd12, 1'b0, 1'b0, 1'b1);

    // Start marker plus two data bits, then silence until timeout
    driveBit(1'b1); driveBit(1'b0); driveBit(1'b1);
    driveBit(1'b1); driveBit(1'b0);
    pushExpect(5'd12, 1'b0, 1'b0, 1'b1, last_edge + TIMEOUT);
    idle(TIMEOUT + 4);
    checkOutput("busy_after_timeout", bus.busy, 0);

    applyStimulus(5'd28, 1'b0, 1'b0, 0, 5'd28, 1'b1, 1'b0, 1'b0);

    // Overlapping marker noise 1,1,0,1
    driveBit(1'b1);
    applyStimulus(5'd16, 1'b1, 1'b0, 0, 5'd16, 1'b1, 1'b0, 1'b0);
    idle(2);
    sendGapped(1'b1, 3);
    applyStimulus(5'd16, 1'b1, 1'b0, 3, 5'd16, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Asynchronous reset in the middle of DATA for value 10
    driveBit(1'b1); driveBit(1'b0); driveBit(1'b1);
    driveBit(1'b0); driveBit(1'b1);
    @(negedge clk);
    bus.barValid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    applyStimulus(5'd10, 1'b1, 1'b0, 0, 5'd10, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd0,  1'b0, 1'b0, 0, 5'd0,  1'b1, 1'b0, 1'b0);
    idle(5);

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
